// File: rtl/noise_bank_if.sv
// Divisor-write port plus per-channel gate inputs and noise/step outputs of noise_bank.
interface noise_bank_if #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 24
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                wr_en;
  logic [CW-1:0]       wr_chan;
  logic [DIV_W-1:0]    wr_div;
  logic [CHANNELS-1:0] trig;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] step;

  modport master (output wr_en, wr_chan, wr_div, trig, input out, step);
  modport slave  (input wr_en, wr_chan, wr_div, trig, output out, step);
endinterface

// File: rtl/noise_bank.sv
// Multi-channel gated Galois-LFSR noise voices, each stepped by its own run-time divisor.
// Define NOISE_BANK_TRIG_SYNC_EN to pass trig through a 2-flop synchroniser (adds 2 cycles).
module noise_bank #(
  parameter int CHANNELS    = 4,
  parameter int LFSR_W      = 8,
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = 56818,
  parameter int RELEASE     = 4
) (
  input logic         clk,
  input logic         reset,
  noise_bank_if.slave bus
);
  localparam logic [LFSR_W-1:0] MASK =
    (LFSR_W == 16) ? LFSR_W'(16'hB400) :
    (LFSR_W == 12) ? LFSR_W'(16'h0E08) : LFSR_W'(16'h00B8);
  localparam logic [7:0] REL_LAST = 8'((RELEASE > 0) ? RELEASE - 1 : 0);

  typedef enum logic [1:0] {IDLE, ON, REL} gate_t;

  logic [DIV_W-1:0]    div   [CHANNELS];
  logic [DIV_W-1:0]    cnt   [CHANNELS];
  logic [LFSR_W-1:0]   lfsr  [CHANNELS];
  logic [7:0]          rel   [CHANNELS];
  gate_t               state [CHANNELS];
  logic [CHANNELS-1:0] tick, wr_hit, trig_s, out_q, step_q;

`ifdef NOISE_BANK_TRIG_SYNC_EN
  logic [CHANNELS-1:0] trig_m;
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_m <= '0;
      trig_s <= '0;
    end else begin
      trig_m <= bus.trig;
      trig_s <= trig_m;
    end
  end
`else
  assign trig_s = bus.trig;
`endif

  // A write to the channel suppresses its tick: the write wins.
  always_comb begin
    tick   = '0;
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = bus.wr_en && (int'(bus.wr_chan) == i);
      tick[i]   = (div[i] != '0) && (cnt[i] == div[i] - DIV_W'(1)) && !wr_hit[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        div[i]   <= DIV_W'(DEFAULT_DIV);
        cnt[i]   <= '0;
        lfsr[i]  <= LFSR_W'(i + 1);
        rel[i]   <= '0;
        state[i] <= IDLE;
      end
      out_q  <= '0;
      step_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_hit[i]) begin
          div[i] <= bus.wr_div;
          cnt[i] <= '0;
        end else if (div[i] == '0 || tick[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DIV_W'(1);
        end

        if (lfsr[i] == '0)
          lfsr[i] <= LFSR_W'(i + 1);
        else if (tick[i])
          lfsr[i] <= lfsr[i][0] ? ((lfsr[i] >> 1) ^ MASK) : (lfsr[i] >> 1);

        out_q[i]  <= lfsr[i][0] & (state[i] != IDLE);
        step_q[i] <= tick[i];

        // A tick coinciding with the fall is not counted toward the release.
        unique case (state[i])
          IDLE: if (trig_s[i]) state[i] <= ON;
          ON: if (!trig_s[i]) begin
            rel[i]   <= '0;
            state[i] <= (RELEASE == 0) ? IDLE : REL;
          end
          REL: if (trig_s[i]) begin
            rel[i]   <= '0;
            state[i] <= ON;
          end else if (tick[i]) begin
            if (rel[i] == REL_LAST) state[i] <= IDLE;
            rel[i] <= rel[i] + 8'd1;
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  assign bus.out  = out_q;
  assign bus.step = step_q;
endmodule

// File: tb/tb_noise_bank.sv
// Self-checking bench for noise_bank: directed scenarios plus random traffic against a behavioural model.
module tb_noise_bank;
  localparam int CH = 4, LW = 8, DW = 24, DDIV = 56818, RELN = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  noise_bank_if #(.CHANNELS(CH), .DIV_W(DW)) bus ();

  noise_bank #(
    .CHANNELS(CH), .LFSR_W(LW), .DIV_W(DW), .DEFAULT_DIV(DDIV), .RELEASE(RELN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Reference model: phase since last write, release as "ticks remaining".
  int         m_div   [CH];
  int         m_phase [CH];
  logic [7:0] m_lfsr  [CH];
  bit         m_on    [CH];
  int         m_rem   [CH];
  logic [CH-1:0] m_out, m_step;
  bit mh, mt;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        m_div[i] = DDIV; m_phase[i] = 0; m_lfsr[i] = 8'(i + 1);
        m_on[i] = 0; m_rem[i] = 0;
      end
      m_out = '0; m_step = '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        mh = bus.wr_en && (int'(bus.wr_chan) == i);
        mt = (m_div[i] != 0) && !mh && (m_phase[i] % m_div[i] == m_div[i] - 1);
        m_out[i]  = m_lfsr[i][0] & (m_on[i] || m_rem[i] > 0);
        m_step[i] = mt;
        if (m_lfsr[i] == 8'h00) m_lfsr[i] = 8'(i + 1);
        else if (mt) m_lfsr[i] = lfsr_next(m_lfsr[i]);
        if (mh) begin
          m_div[i] = int'(bus.wr_div); m_phase[i] = 0;
        end else if (m_div[i] == 0) m_phase[i] = 0;
        else m_phase[i] = (m_phase[i] + 1) % m_div[i];
        if (bus.trig[i]) begin
          m_on[i] = 1; m_rem[i] = 0;
        end else if (m_on[i]) begin
          m_on[i] = 0; m_rem[i] = RELN;
        end else if (m_rem[i] > 0 && mt) m_rem[i]--;
      end
    end
  end

  logic [7:0] exp_l [5];

  task automatic next_cyc;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int ch, input int d);
    bus.wr_en = 1'b1; bus.wr_chan = 2'(ch); bus.wr_div = DW'(d);
    next_cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.wr_en = 1'b0; bus.wr_chan = '0; bus.wr_div = '0; bus.trig = '0;
    repeat (3) next_cyc();
    n_tests++; if (bus.out !== 4'h0) begin n_fail++; $display("FAIL reset_out got %h want 0", bus.out); end
    n_tests++; if (bus.step !== 4'h0) begin n_fail++; $display("FAIL reset_step got %h want 0", bus.step); end
    for (int i = 0; i < CH; i++) begin
      n_tests++;
      if (dut.lfsr[i] !== 8'(i + 1)) begin
        n_fail++; $display("FAIL reset_seed ch%0d got %h want %h", i, dut.lfsr[i], 8'(i + 1));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_lfsr_seq;
    int k = 0;
    bit pend = 0;
    exp_l[0] = 8'hB8; exp_l[1] = 8'h5C; exp_l[2] = 8'h2E; exp_l[3] = 8'h17; exp_l[4] = 8'hB3;
    bus.trig[0] = 1'b1;
    do_write(0, 3);
    for (int c = 1; c <= 16; c++) begin
      next_cyc();
      if (pend) begin
        pend = 0; n_tests++;
        if (bus.out[0] !== exp_l[k-1][0]) begin
          n_fail++; $display("FAIL seq_out step%0d got %b want %b", k, bus.out[0], exp_l[k-1][0]);
        end
      end
      if (bus.step[0] && k < 5) begin
        n_tests++;
        if (c != 3 * (k + 1)) begin n_fail++; $display("FAIL seq_period step%0d at cycle %0d want %0d", k, c, 3 * (k + 1)); end
        n_tests++;
        if (dut.lfsr[0] !== exp_l[k]) begin n_fail++; $display("FAIL seq_lfsr step%0d got %h want %h", k, dut.lfsr[0], exp_l[k]); end
        k++; pend = 1;
      end
    end
    n_tests++; if (k != 5) begin n_fail++; $display("FAIL seq_count got %0d steps want 5", k); end
  endtask

  task automatic test_div_zero;
    int steps = 0, changes = 0;
    logic o0;
    do_write(1, 0);
    o0 = bus.out[1];
    for (int c = 0; c < 1000; c++) begin
      next_cyc();
      if (bus.step[1]) steps++;
      if (bus.out[1] !== o0) changes++;
    end
    n_tests++; if (steps != 0) begin n_fail++; $display("FAIL div0_step got %0d pulses want 0", steps); end
    n_tests++; if (changes != 0) begin n_fail++; $display("FAIL div0_out got %0d changes want 0", changes); end
  endtask

  task automatic test_release;
    int seen = 0, x = 0, late = 0, bad = 0;
    do_write(2, 5);
    bus.trig[2] = 1'b1;
    repeat (12) next_cyc();
    bus.trig[2] = 1'b0;
    next_cyc();
    for (int c = 1; c <= 40; c++) begin
      next_cyc();
      if (bus.out[2] !== m_out[2]) bad++;
      if (x != 0 && bus.out[2] !== 1'b0) late++;
      if (x == 0 && bus.step[2]) begin seen++; if (seen == RELN) x = c; end
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rel_model got %0d mismatching cycles want 0", bad); end
    n_tests++; if (x < 16 || x > 20) begin n_fail++; $display("FAIL rel_len last step at %0d want 16..20", x); end
    n_tests++; if (late != 0) begin n_fail++; $display("FAIL rel_tail out high %0d cycles after close want 0", late); end
  endtask

  task automatic test_retrigger;
    int seen = 0, x = 0, late = 0, bad = 0;
    bus.trig[2] = 1'b1;
    repeat (8) next_cyc();
    bus.trig[2] = 1'b0;
    next_cyc();
    for (int c = 0; c < 30 && seen < 2; c++) begin
      next_cyc();
      if (bus.step[2]) seen++;
    end
    n_tests++; if (seen != 2) begin n_fail++; $display("FAIL retrig_wait got %0d steps want 2", seen); end
    bus.trig[2] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      next_cyc();
      if (bus.out[2] !== m_out[2]) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL retrig_on got %0d mismatching cycles want 0", bad); end
    bus.trig[2] = 1'b0;
    next_cyc();
    seen = 0;
    for (int c = 1; c <= 40; c++) begin
      next_cyc();
      if (x != 0 && bus.out[2] !== 1'b0) late++;
      if (x == 0 && bus.step[2]) begin seen++; if (seen == RELN) x = c; end
    end
    n_tests++; if (x < 16 || x > 20) begin n_fail++; $display("FAIL retrig_rel last step at %0d want 16..20", x); end
    n_tests++; if (late != 0) begin n_fail++; $display("FAIL retrig_tail out high %0d cycles want 0", late); end
  endtask

  task automatic test_collision;
    int w = 0;
    do_write(3, 4);
    for (int c = 0; c < 20 && w == 0; c++) begin
      if (m_phase[3] == m_div[3] - 1) w = 1;
      else next_cyc();
    end
    n_tests++; if (w == 0) begin n_fail++; $display("FAIL coll_sync got no tick cycle want one within 20"); end
    do_write(3, 6);
    n_tests++; if (bus.step[3] !== 1'b0) begin n_fail++; $display("FAIL coll_step got %b want 0", bus.step[3]); end
    for (int e = 1; e <= 6; e++) begin
      next_cyc();
      n_tests++;
      if (bus.step[3] !== (e == 6)) begin
        n_fail++; $display("FAIL coll_next edge%0d got %b want %b", e, bus.step[3], (e == 6));
      end
    end
  endtask

  task automatic test_random;
    int bo = 0, bs = 0;
    for (int c = 0; c < 1500; c++) begin
      bus.wr_en = ($urandom_range(0, 9) == 0);
      bus.wr_chan = 2'($urandom_range(0, CH - 1));
      bus.wr_div = DW'($urandom_range(0, 7));
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 7) == 0) bus.trig[i] = ~bus.trig[i];
      next_cyc();
      if (bus.out !== m_out) bo++;
      if (bus.step !== m_step) bs++;
    end
    bus.wr_en = 1'b0;
    n_tests++; if (bo != 0) begin n_fail++; $display("FAIL rand_out got %0d mismatching cycles want 0", bo); end
    n_tests++; if (bs != 0) begin n_fail++; $display("FAIL rand_step got %0d mismatching cycles want 0", bs); end
  endtask

  task automatic test_reset_mid;
    int hi = 0;
    bus.trig = 4'hF;
    for (int i = 0; i < CH; i++) do_write(i, 3);
    repeat (6) next_cyc();
    bus.trig = 4'h0;
    repeat (4) next_cyc();
    reset = 1'b1; bus.trig = 4'hF; bus.wr_en = 1'b1; bus.wr_chan = 2'd0; bus.wr_div = DW'(1);
    next_cyc();
    reset = 1'b0; bus.trig = 4'h0; bus.wr_en = 1'b0;
    n_tests++; if (bus.out !== 4'h0) begin n_fail++; $display("FAIL rmid_out got %h want 0", bus.out); end
    n_tests++; if (bus.step !== 4'h0) begin n_fail++; $display("FAIL rmid_step got %h want 0", bus.step); end
    for (int i = 0; i < CH; i++) begin
      n_tests++;
      if (dut.lfsr[i] !== 8'(i + 1)) begin
        n_fail++; $display("FAIL rmid_seed ch%0d got %h want %h", i, dut.lfsr[i], 8'(i + 1));
      end
    end
    n_tests++; if (dut.div[0] !== DW'(DDIV)) begin n_fail++; $display("FAIL rmid_div got %0d want %0d", dut.div[0], DDIV); end
    for (int c = 0; c < 8; c++) begin
      next_cyc();
      if (bus.out !== 4'h0) hi++;
    end
    n_tests++; if (hi != 0) begin n_fail++; $display("FAIL rmid_idle out high %0d cycles want 0", hi); end
  endtask

  initial begin
    test_reset();
    test_lfsr_seq();
    test_div_zero();
    test_release();
    test_retrigger();
    test_collision();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
